// File: rtl/dmc_pkg.sv
// Shared width constants and cache-line record for the direct-mapped cache.
//   DMC_*_W    : default geometry (32-bit address/data, 64 lines, word offset)
//   dmc_line_t : one cache line {valid, tag, data} at the default geometry
package dmc_pkg;

  localparam int unsigned DMC_ADDR_W   = 32;
  localparam int unsigned DMC_DATA_W   = 32;
  localparam int unsigned DMC_INDEX_W  = 6;
  localparam int unsigned DMC_OFFSET_W = 2;
  localparam int unsigned DMC_TAG_W    = DMC_ADDR_W - DMC_INDEX_W - DMC_OFFSET_W;

  typedef struct packed {
    logic                  valid;
    logic [DMC_TAG_W-1:0]  tag;
    logic [DMC_DATA_W-1:0] data;
  } dmc_line_t;

endpackage : dmc_pkg

// File: rtl/dmc_line_array.sv
// Line storage for the direct-mapped cache: valid bits (async reset) plus
// unreset tag and data arrays. One synchronous write port, one
// combinational read port that returns pre-edge contents.
//   clk_i, areset_i         : clock, async active-high reset (clears valid)
//   we_i, wr_index_i,
//   wr_tag_i, wr_data_i     : write port, fills and validates a line
//   rd_index_i              : read line select
//   rd_valid_c, rd_tag_c,
//   rd_data_c               : combinational read data
module dmc_line_array
  import dmc_pkg::*;
#(
  parameter int unsigned DATA_W  = DMC_DATA_W,
  parameter int unsigned TAG_W   = DMC_TAG_W,
  parameter int unsigned INDEX_W = DMC_INDEX_W
) (
  input  logic               clk_i,
  input  logic               areset_i,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_c,
  output logic [TAG_W-1:0]   rd_tag_c,
  output logic [DATA_W-1:0]  rd_data_c
);

  localparam int unsigned LINES = 32'(1) << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // A write always (re)validates its line; nothing ever invalidates except reset.
  always_comb begin
    valid_d = valid_q;
    if (we_i) begin
      valid_d[wr_index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data payload is don't-care while the line is invalid, so no reset.
  always_ff @(posedge clk_i) begin
    if (we_i && !areset_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_c = valid_q[rd_index_i];
  assign rd_tag_c   = tag_q[rd_index_i];
  assign rd_data_c  = data_q[rd_index_i];

endmodule : dmc_line_array

// File: rtl/direct_mapping_cache.sv
// Direct-mapped cache, one word per line, write-allocate on explicit writes
// only. Lookups are registered: the result appears one cycle after the
// request edge.
//   clk_i, areset_i : clock, async active-high reset
//   write_enable_i  : 1 = write cycle, 0 = lookup cycle
//   data_i, addr_i  : write data, request address
//   data_o          : lookup data (0 unless hit)
//   hit_o, miss_o   : lookup result, both 0 after a write cycle
module direct_mapping_cache
  import dmc_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMC_ADDR_W,
  parameter int unsigned DATA_W   = DMC_DATA_W,
  parameter int unsigned INDEX_W  = DMC_INDEX_W,
  parameter int unsigned OFFSET_W = DMC_OFFSET_W
) (
  input  logic              clk_i,
  input  logic              areset_i,
  input  logic              write_enable_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o,
  output logic              miss_o
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic [INDEX_W-1:0] index_c;
  logic [TAG_W-1:0]   tag_c;
  logic               unused_offset_c;

  logic               line_valid_c;
  logic [TAG_W-1:0]   line_tag_c;
  logic [DATA_W-1:0]  line_data_c;

  logic [DATA_W-1:0]  data_q, data_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  // Pure bit-slice decode: every index value maps to its own line.
  assign index_c         = addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag_c           = addr_i[ADDR_W-1:OFFSET_W+INDEX_W];
  assign unused_offset_c = ^addr_i[OFFSET_W-1:0];

  dmc_line_array #(
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_lines (
    .clk_i      (clk_i),
    .areset_i   (areset_i),
    .we_i       (write_enable_i),
    .wr_index_i (index_c),
    .wr_tag_i   (tag_c),
    .wr_data_i  (data_i),
    .rd_index_i (index_c),
    .rd_valid_c (line_valid_c),
    .rd_tag_c   (line_tag_c),
    .rd_data_c  (line_data_c)
  );

  // Lookup compare; write cycles report neither hit nor miss.
  always_comb begin
    hit_d  = 1'b0;
    miss_d = 1'b0;
    data_d = '0;
    if (!write_enable_i) begin
      if (line_valid_c && (line_tag_c == tag_c)) begin
        hit_d  = 1'b1;
        data_d = line_data_c;
      end else begin
        miss_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      data_q <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      data_q <= data_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign data_o = data_q;
  assign hit_o  = hit_q;
  assign miss_o = miss_q;

endmodule : direct_mapping_cache

// File: tb/tb_direct_mapping_cache.sv
// Directed self-checking bench for direct_mapping_cache.
module tb_direct_mapping_cache;

  logic        clk;
  logic        areset;
  logic        we;
  logic [31:0] din;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        hit;
  logic        miss;

  int n_checks = 0;
  int n_fail   = 0;

  direct_mapping_cache dut (
    .clk_i          (clk),
    .areset_i       (areset),
    .write_enable_i (we),
    .data_i         (din),
    .addr_i         (addr),
    .data_o         (dout),
    .hit_o          (hit),
    .miss_o         (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic        exp_miss;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic eh, input logic em, input logic [31:0] ed);
    check({name, ".hit"},  32'(hit),  32'(eh));
    check({name, ".miss"}, 32'(miss), 32'(em));
    check({name, ".data"}, dout, ed);
    check({name, ".excl"}, 32'(hit & miss), 32'd0);
  endtask

  // Drive one request at the falling edge; sample its registered result #1 after the rising edge.
  task automatic apply(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic eh, input logic em, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.data = d;
    v.exp_hit = eh; v.exp_miss = em; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("cold_lookup",    1'b0, 32'h328921ED, 32'h0,        1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("wr_deadbeef",    1'b1, 32'h328921EC, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("hit_offset_ign", 1'b0, 32'h328921ED, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk("wr_evict",       1'b1, 32'h000000EC, 32'h11111111, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("evicted_miss",   1'b0, 32'h328921EC, 32'h0,        1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("new_tag_hit",    1'b0, 32'h000000EC, 32'h0,        1'b1, 1'b0, 32'h11111111));
    vecs.push_back(mk("wr_idx0",        1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("wr_idx63",       1'b1, 32'h000000FC, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("hit_idx0",       1'b0, 32'h00000000, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5));
    vecs.push_back(mk("hit_idx63",      1'b0, 32'h000000FF, 32'h0,        1'b1, 1'b0, 32'h5A5A5A5A));
    vecs.push_back(mk("miss_idx63_tag", 1'b0, 32'h000001FC, 32'h0,        1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("miss_idx0_tag",  1'b0, 32'h00000100, 32'h0,        1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("miss_no_alloc",  1'b0, 32'h000000FC, 32'h0,        1'b1, 1'b0, 32'h5A5A5A5A));
    vecs.push_back(mk("wr_idx1",        1'b1, 32'h00000104, 32'h12345678, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("hit_idx1",       1'b0, 32'h00000104, 32'h0,        1'b1, 1'b0, 32'h12345678));
    vecs.push_back(mk("idx0_intact",    1'b0, 32'h00000002, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5));

    // Power-on reset
    areset = 1'b1;
    we     = 1'b0;
    din    = '0;
    addr   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    areset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].we, vecs[i].addr, vecs[i].data);
      check_outs(vecs[i].name, vecs[i].exp_hit, vecs[i].exp_miss, vecs[i].exp_data);
    end

    // Back-to-back write then lookup of the same line sees the new data
    apply(1'b1, 32'h000000EC, 32'hCAFEF00D);
    check_outs("b2b_wr", 1'b0, 1'b0, 32'h0);
    apply(1'b0, 32'h000000EC, 32'h0);
    check_outs("b2b_rd", 1'b1, 1'b0, 32'hCAFEF00D);

    // Mid-operation reset: outputs drop immediately, in-flight write abandoned
    apply(1'b0, 32'h00000000, 32'h0);
    check_outs("pre_rst_hit", 1'b1, 1'b0, 32'hA5A5A5A5);
    #2;
    areset = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    we   = 1'b1;
    addr = 32'h00000200;
    din  = 32'hBADBAD00;
    @(posedge clk);
    #1;
    check_outs("rst_held", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    areset = 1'b0;
    we     = 1'b0;
    apply(1'b0, 32'h00000200, 32'h0);
    check_outs("rst_wr_abandon", 1'b0, 1'b1, 32'h0);
    apply(1'b0, 32'h00000000, 32'h0);
    check_outs("rst_old_miss", 1'b0, 1'b1, 32'h0);
    apply(1'b0, 32'h000000EC, 32'h0);
    check_outs("rst_old_miss2", 1'b0, 1'b1, 32'h0);

    // Cache works again after reset
    apply(1'b1, 32'h000000EC, 32'h0F0F0F0F);
    check_outs("post_rst_wr", 1'b0, 1'b0, 32'h0);
    apply(1'b0, 32'h000000EC, 32'h0);
    check_outs("post_rst_hit", 1'b1, 1'b0, 32'h0F0F0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_direct_mapping_cache
